key_search_scheduler: RTL and testbench
=======================================

Name: key_search_scheduler

Overview:
- Top-level controller for the brute-force RC4 key search.
- Hands consecutive candidate keys to NUM_CORES independent decrypt cores and collects each core's pass/fail verdict.
- On the first pass it freezes the search and broadcasts stop. If the key space runs out with no pass, it reports exhaustion.
- Replaces per-core hardwired key sequencing. Sits between the board top level (switches/LEDs/HEX) and the core instances.

Parameters:
- NUM_CORES, 4, number of decrypt cores scheduled (1..16).
- KEY_WIDTH, 24, width of a candidate secret key.
- KEY_MAX, 24'h3FFFFF, last key in the search space (inclusive); overridable for simulation.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin search; honoured only in IDLE, FOUND or EXHAUSTED
- core_done  in  NUM_CORES  per-core 1-cycle verdict-valid pulse
- core_pass  in  NUM_CORES  per-core verdict, qualified by core_done (1 = message decoded)
- core_start  out  NUM_CORES  registered 1-cycle pulse launching core i on core_key[i]
- core_key  out  NUM_CORES*KEY_WIDTH  key for core i; slice i = bits [i*KEY_WIDTH +: KEY_WIDTH]; held until core i's next start
- stop  out  1  broadcast halt to all cores; high in FOUND only
- busy  out  1  high in DISPATCH/RUN
- found  out  1  high in FOUND
- exhausted  out  1  high in EXHAUSTED
- found_key  out  KEY_WIDTH  winning key, valid while found=1
- keys_tried  out  KEY_WIDTH+1  count of fail verdicts accepted since start

Behaviour:
- Reset: every output is 0 and state = IDLE. Internal next_key (KEY_WIDTH+1 bits) = 0, busy_mask = 0, round-robin pointer rr = 0. Reset mid-search discards all in-flight work.
- States: IDLE, DISPATCH, RUN, FOUND, EXHAUSTED.
- IDLE --start--> DISPATCH. Entry clears next_key, keys_tried, found_key, busy_mask and rr.
- DISPATCH is one cycle, then RUN. No core_start is issued in DISPATCH itself.
- Grant in RUN, evaluated each cycle T:
  - Candidates are cores with busy_mask[i]=0 as registered at the start of T.
  - Pick the first candidate at or after rr, wrapping modulo NUM_CORES.
  - A grant requires next_key <= KEY_MAX and no accepted pass in T.
  - Effect at T+1: core_start[i]=1, core_key[i]=next_key[KEY_WIDTH-1:0], busy_mask[i]=1, next_key+1, rr=i+1 mod NUM_CORES.
  - At most one grant per cycle.
- Verdict accept: core_done[i] is accepted only if busy_mask[i]=1. Done from an idle core is ignored.
- On an accepted verdict, busy_mask[i] clears at T+1. A core that reports in T can be regranted in T+1 at the earliest (visible core_start at T+2).
- Fail verdict: keys_tried increments by the number of fail verdicts accepted in T (popcount).
- Pass verdict in RUN:
  - Go to FOUND at T+1 with found_key = core_key of the lowest-index passing core; simultaneous passes resolve to the lowest index.
  - The grant in T is suppressed.
  - stop=1 and found=1 are held until reset or start.
  - Fail verdicts in the same cycle still count.
- Exhaustion: next_key > KEY_MAX and busy_mask == 0 (after applying this cycle's verdicts) → EXHAUSTED at T+1, exhausted=1, stop=0.
- A pass takes precedence over exhaustion in the same cycle.
- FOUND/EXHAUSTED --start--> DISPATCH, with the same clearing as from IDLE. start during DISPATCH/RUN is ignored.
- In FOUND and EXHAUSTED, core_done is ignored.
- core_key slices are not cleared on restart. They change only on a grant.

Optional Feature:
- Macro: KEY_SCHED_PERF_EN.
- When defined:
  - Adds output search_cycles (32 bits), reset to 0.
  - Cleared on entry to DISPATCH; increments every cycle in DISPATCH/RUN; frozen in FOUND/EXHAUSTED.
  - Saturates at 32'hFFFFFFFF.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset held 2 cycles with core_done=4'b1111 → all outputs 0; after release, no core_start without start.
- start pulse (NUM_CORES=4) → DISPATCH, then core_start = 0001, 0010, 0100, 1000 on consecutive cycles with keys 0, 1, 2, 3; busy=1.
- After full dispatch, core_done[1]=1, core_pass[1]=0 → keys_tried=1; two cycles later core_start[1]=1 with core_key[1]=4.
- Cores 2 and 0 pass in the same cycle (keys 2, 0) → next cycle found=1, stop=1, found_key=0, no further core_start; a later core_done is ignored.
- KEY_MAX=5, every verdict fail → exactly 6 grants (keys 0..5), then exhausted=1, keys_tried=6, found=0, stop=0; start relaunches from key 0.
- Reset asserted mid-RUN with done pulses in flight → all outputs 0 next cycle; core_done[3] pulse in IDLE leaves keys_tried=0. With KEY_SCHED_PERF_EN, search_cycles freezes at FOUND.

Source files
------------

// File: rtl/key_search_scheduler.sv
// Round-robin RC4 key dispatcher: hands consecutive keys to NUM_CORES decrypt cores, halts on first pass, flags exhaustion.
// Define KEY_SCHED_PERF_EN to add the saturating search_cycles counter.
module key_search_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX = 24'h3FFFFF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES-1:0]           core_pass,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  output logic                           stop,
  output logic                           busy,
  output logic                           found,
  output logic                           exhausted,
  output logic [KEY_WIDTH-1:0]           found_key,
  output logic [KEY_WIDTH:0]             keys_tried
`ifdef KEY_SCHED_PERF_EN
  ,
  output logic [31:0]                    search_cycles
`endif
);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DISPATCH  = 3'd1;
  localparam logic [2:0] S_RUN       = 3'd2;
  localparam logic [2:0] S_FOUND     = 3'd3;
  localparam logic [2:0] S_EXHAUSTED = 3'd4;
  localparam logic [KEY_WIDTH:0] KEY_ONE = 1;
  localparam logic [IDX_W-1:0] IDX_ONE = 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CORES - 1);

  logic [2:0]             state;
  logic [KEY_WIDTH:0]     next_key;
  logic [NUM_CORES-1:0]   busy_mask;
  logic [IDX_W-1:0]       rr;
  logic [KEY_WIDTH-1:0]   key_q [NUM_CORES];

  logic [NUM_CORES-1:0]   accepted;
  logic [NUM_CORES-1:0]   pass_vec;
  logic [NUM_CORES-1:0]   busy_after;
  logic [KEY_WIDTH:0]     fail_cnt;
  logic                   pass_any;
  logic                   any_free;
  logic                   grant_vld;
  logic                   key_left;
  logic                   restart;
  logic [IDX_W-1:0]       pass_idx;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       grant_next;
  int                     cand;

  assign restart  = start && (state == S_IDLE || state == S_FOUND || state == S_EXHAUSTED);
  assign key_left = (next_key <= {1'b0, KEY_MAX});

  always_comb begin
    accepted   = '0;
    pass_vec   = '0;
    fail_cnt   = '0;
    pass_idx   = '0;
    grant_idx  = '0;
    any_free   = 1'b0;
    cand       = 0;
    if (state == S_RUN) begin
      accepted = core_done & busy_mask;
      pass_vec = accepted & core_pass;
    end
    busy_after = busy_mask & ~accepted;
    pass_any   = |pass_vec;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (accepted[i] && !core_pass[i]) fail_cnt = fail_cnt + KEY_ONE;
      if (pass_vec[i]) pass_idx = IDX_W'(i);
    end
    // Walk backwards from rr+N-1 so the last hit is the first free core at/after rr.
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      cand = int'(rr) + k;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (!busy_mask[cand]) begin
        any_free  = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
    grant_vld  = (state == S_RUN) && key_left && !pass_any && any_free;
    grant_next = (grant_idx == IDX_LAST) ? '0 : grant_idx + IDX_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      next_key   <= '0;
      busy_mask  <= '0;
      rr         <= '0;
      core_start <= '0;
      found_key  <= '0;
      keys_tried <= '0;
      for (int i = 0; i < NUM_CORES; i++) key_q[i] <= '0;
    end else begin
      core_start <= '0;
      if (restart) begin
        state      <= S_DISPATCH;
        next_key   <= '0;
        keys_tried <= '0;
        found_key  <= '0;
        busy_mask  <= '0;
        rr         <= '0;
      end else if (state == S_DISPATCH) begin
        state <= S_RUN;
      end else if (state == S_RUN) begin
        keys_tried <= keys_tried + fail_cnt;
        busy_mask  <= busy_after;
        if (pass_any) begin
          state     <= S_FOUND;
          found_key <= key_q[pass_idx];
        end else if (grant_vld) begin
          core_start[grant_idx] <= 1'b1;
          key_q[grant_idx]      <= next_key[KEY_WIDTH-1:0];
          busy_mask             <= busy_after | (NUM_CORES'(1) << grant_idx);
          next_key              <= next_key + KEY_ONE;
          rr                    <= grant_next;
        end else if (!key_left && busy_after == '0) begin
          state <= S_EXHAUSTED;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_key
    assign core_key[g*KEY_WIDTH +: KEY_WIDTH] = key_q[g];
  end

  assign stop      = (state == S_FOUND);
  assign found     = (state == S_FOUND);
  assign exhausted = (state == S_EXHAUSTED);
  assign busy      = (state == S_DISPATCH) || (state == S_RUN);

`ifdef KEY_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      search_cycles <= '0;
    end else if (busy && search_cycles != 32'hFFFF_FFFF) begin
      search_cycles <= search_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_key_search_scheduler.sv
// Randomized bench for key_search_scheduler with an emulated core farm and an in-bench reference model.
module tb_key_search_scheduler;
  localparam int NC = 4;
  localparam int KW = 8;
  localparam logic [KW-1:0] KMAX = 8'd5;
  localparam int ST_IDLE = 0, ST_DISP = 1, ST_RUN = 2, ST_FOUND = 3, ST_EXH = 4;

  logic clk = 1'b0;
  logic reset, start;
  logic [NC-1:0] core_done, core_pass, core_start;
  logic [NC*KW-1:0] core_key;
  logic stop, busy, found, exhausted;
  logic [KW-1:0] found_key;
  logic [KW:0] keys_tried;
`ifdef KEY_SCHED_PERF_EN
  logic [31:0] search_cycles;
`endif

  key_search_scheduler #(.NUM_CORES(NC), .KEY_WIDTH(KW), .KEY_MAX(KMAX)) dut (
    .clk(clk), .reset(reset), .start(start), .core_done(core_done), .core_pass(core_pass),
    .core_start(core_start), .core_key(core_key), .stop(stop), .busy(busy), .found(found),
    .exhausted(exhausted), .found_key(found_key), .keys_tried(keys_tried)
`ifdef KEY_SCHED_PERF_EN
    , .search_cycles(search_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: search state expressed as plain ints/arrays.
  int            m_st;
  int            m_rr;
  logic [KW:0]   m_next, m_tried;
  logic [KW-1:0] m_fkey;
  logic [NC-1:0] m_busy, m_cs;
  logic [KW-1:0] m_key [NC];
  logic [31:0]   m_cyc;

  task automatic model_edge(input logic st, input logic [NC-1:0] d, input logic [NC-1:0] p, input logic rst);
    logic [NC-1:0] acc, pas, old_busy;
    int c;
    m_cs = '0;
    if (rst) begin
      m_st = ST_IDLE; m_rr = 0; m_next = '0; m_tried = '0; m_fkey = '0; m_busy = '0; m_cyc = '0;
      for (int i = 0; i < NC; i++) m_key[i] = '0;
      return;
    end
    if ((m_st == ST_DISP || m_st == ST_RUN) && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
    case (m_st)
      ST_DISP: m_st = ST_RUN;
      ST_RUN: begin
        acc = d & m_busy;
        pas = acc & p;
        old_busy = m_busy;
        m_tried = m_tried + (KW+1)'($countones(acc & ~p));
        m_busy = m_busy & ~acc;
        if (pas != '0) begin
          c = 0;
          for (int i = NC - 1; i >= 0; i--) if (pas[i]) c = i;
          m_fkey = m_key[c];
          m_st = ST_FOUND;
        end else if (m_next <= {1'b0, KMAX}) begin
          for (int k = 0; k < NC; k++) begin
            c = (m_rr + k) % NC;
            if (!old_busy[c]) begin
              m_cs[c] = 1'b1; m_key[c] = m_next[KW-1:0]; m_busy[c] = 1'b1;
              m_next = m_next + 1; m_rr = (c + 1) % NC;
              break;
            end
          end
        end else if (m_busy == '0) begin
          m_st = ST_EXH;
        end
      end
      default: if (st) begin
        m_st = ST_DISP; m_rr = 0; m_next = '0; m_tried = '0; m_fkey = '0; m_busy = '0; m_cyc = '0;
      end
    endcase
  endtask

  function automatic logic [KW-1:0] key_of(input int i);
    return core_key[i*KW +: KW];
  endfunction

  task automatic compare_all();
    check("core_start", 64'(core_start), 64'(m_cs));
    for (int i = 0; i < NC; i++) check($sformatf("core_key%0d", i), 64'(key_of(i)), 64'(m_key[i]));
    check("stop", 64'(stop), 64'(m_st == ST_FOUND));
    check("found", 64'(found), 64'(m_st == ST_FOUND));
    check("exhausted", 64'(exhausted), 64'(m_st == ST_EXH));
    check("busy", 64'(busy), 64'(m_st == ST_DISP || m_st == ST_RUN));
    check("found_key", 64'(found_key), 64'(m_fkey));
    check("keys_tried", 64'(keys_tried), 64'(m_tried));
`ifdef KEY_SCHED_PERF_EN
    check("search_cycles", 64'(search_cycles), 64'(m_cyc));
`endif
  endtask

  task automatic cyc(input logic st, input logic [NC-1:0] d, input logic [NC-1:0] p, input logic rst);
    start = st; core_done = d; core_pass = p; reset = rst;
    @(posedge clk);
    model_edge(st, d, p, rst);
    #1;
    compare_all();
  endtask

  // Core farm emulation: each launched core answers after 1..5 cycles.
  int   pend [NC];
  logic pend_pass [NC];
  logic [NC-1:0] e_d, e_p;

  task automatic emu_clear();
    for (int i = 0; i < NC; i++) begin pend[i] = 0; pend_pass[i] = 1'b0; end
  endtask

  task automatic emu_inputs(input int spur_pct);
    e_d = '0; e_p = '0;
    for (int i = 0; i < NC; i++) begin
      if (pend[i] > 0) begin
        pend[i]--;
        if (pend[i] == 0) begin e_d[i] = 1'b1; e_p[i] = pend_pass[i]; end
      end else if (int'($urandom_range(0, 99)) < spur_pct) begin
        e_d[i] = 1'b1; e_p[i] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic emu_track(input int pass_pct, input logic rst);
    if (rst) emu_clear();
    else for (int i = 0; i < NC; i++)
      if (m_cs[i]) begin
        pend[i] = int'($urandom_range(1, 5));
        pend_pass[i] = (int'($urandom_range(0, 99)) < pass_pct);
      end
  endtask

  initial begin
    logic [NC-1:0] oh;
    logic [31:0] sc_snap;
    logic st, rs;
    int grants;
    bit seen;
    emu_clear();

    // Reset with stray done pulses.
    cyc(1'b0, 4'b1111, 4'b0000, 1'b1);
    cyc(1'b0, 4'b1111, 4'b1111, 1'b1);
    check("rst_start", 64'(core_start), 64'd0);
    check("rst_keys", 64'(core_key), 64'd0);
    check("rst_flags", 64'({stop, busy, found, exhausted}), 64'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b0);
    check("idle_no_start", 64'(core_start), 64'd0);

    // Launch and full dispatch.
    cyc(1'b1, '0, '0, 1'b0);
    check("disp_busy", 64'(busy), 64'd1);
    check("disp_no_start", 64'(core_start), 64'd0);
    cyc(1'b0, '0, '0, 1'b0);
    check("run_no_start", 64'(core_start), 64'd0);
    for (int i = 0; i < NC; i++) begin
      cyc(1'b0, '0, '0, 1'b0);
      oh = 4'b0001 << i;
      check("dispatch_start", 64'(core_start), 64'(oh));
      check("dispatch_key", 64'(key_of(i)), 64'(i));
    end

    // Core 1 fails -> regranted with key 4 two cycles later.
    cyc(1'b0, 4'b0010, 4'b0000, 1'b0);
    check("fail_count", 64'(keys_tried), 64'd1);
    check("no_early_regrant", 64'(core_start), 64'd0);
    cyc(1'b0, '0, '0, 1'b0);
    check("regrant_start", 64'(core_start), 64'b0010);
    check("regrant_key", 64'(key_of(1)), 64'd4);

    // Cores 0 and 2 pass together -> lowest index wins.
    cyc(1'b0, 4'b0101, 4'b0101, 1'b0);
    check("found", 64'(found), 64'd1);
    check("found_stop", 64'(stop), 64'd1);
    check("found_key", 64'(found_key), 64'd0);
    check("found_no_start", 64'(core_start), 64'd0);
`ifdef KEY_SCHED_PERF_EN
    sc_snap = search_cycles;
`else
    sc_snap = 32'd0;
`endif
    cyc(1'b0, 4'b1000, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0010, 4'b0010, 1'b0);
    check("found_ignores_done", 64'(keys_tried), 64'd1);
    check("found_held_key", 64'(found_key), 64'd0);
`ifdef KEY_SCHED_PERF_EN
    check("perf_frozen", 64'(search_cycles), 64'(sc_snap));
`endif

    // Exhaustion with every verdict failing.
    emu_clear();
    cyc(1'b1, '0, '0, 1'b0);
    emu_track(0, 1'b0);
    grants = 0;
    for (int t = 0; t < 100 && !exhausted; t++) begin
      emu_inputs(0);
      cyc(1'b0, e_d, e_p, 1'b0);
      emu_track(0, 1'b0);
      grants += $countones(core_start);
    end
    check("exh_reached", 64'(exhausted), 64'd1);
    check("exh_grants", 64'(grants), 64'd6);
    check("exh_tried", 64'(keys_tried), 64'd6);
    check("exh_stop_found", 64'({stop, found}), 64'd0);

    // Relaunch starts from key 0 on core 0.
    cyc(1'b1, '0, '0, 1'b0);
    emu_track(0, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      emu_inputs(0);
      cyc(1'b0, e_d, e_p, 1'b0);
      emu_track(0, 1'b0);
      seen = (core_start != '0);
    end
    check("relaunch_seen", 64'(seen), 64'd1);
    check("relaunch_start", 64'(core_start), 64'b0001);
    check("relaunch_key", 64'(key_of(0)), 64'd0);
    for (int t = 0; t < 3; t++) begin
      emu_inputs(0);
      cyc(1'b0, e_d, e_p, 1'b0);
      emu_track(0, 1'b0);
    end

    // Reset mid-run with done pulses in flight.
    cyc(1'b0, 4'b1111, 4'b0000, 1'b1);
    emu_clear();
    check("midrst_outs", 64'({core_start, stop, busy, found, exhausted}), 64'd0);
    check("midrst_keys", 64'(core_key), 64'd0);
    check("midrst_tried", 64'(keys_tried), 64'd0);
    cyc(1'b0, 4'b1000, 4'b0000, 1'b0);
    check("idle_done_ignored", 64'(keys_tried), 64'd0);

    // Randomized traffic: restarts, spurious dones, passes, occasional reset.
    for (int t = 0; t < 4000; t++) begin
      emu_inputs(3);
      st = (t == 0) || (int'($urandom_range(0, 99)) < 6);
      rs = (int'($urandom_range(0, 499)) == 0);
      cyc(st, e_d, e_p, rs);
      emu_track(8, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
